sram_rw_port_ctrl: RTL
======================

// Module: sram_rw_port_ctrl
// PURPOSE
//  Initiator for the RW port (port 0) of the 32x256 OpenRAM SRAM macro. Converts a valid/ready request
//  channel (read or byte-masked write) into correctly timed csb/web/wmask/addr/din and captures dout.
//  Returns one response per request on a valid/ready response channel.
//  Optional post-reset zero-fill engine sweeps the whole array before user traffic is accepted.
// PARAMETERS
//  DATA_WIDTH  32  SRAM word width
//  ADDR_WIDTH  8   SRAM address width; RAM_DEPTH = 1<<ADDR_WIDTH
//  NUM_WMASKS  4   byte-lane write mask width (DATA_WIDTH/8)
//  INIT_EN     1   1 = fill every word with INIT_VALUE after reset; 0 = skip
//  INIT_VALUE  0   DATA_WIDTH-bit fill pattern
// PORTS
//  clk         in   1           single clock; also drives the SRAM clk0
//  resetn      in   1           asynchronous, active-low reset
//  req_valid   in   1           request present
//  req_ready   out  1           request accepted when req_valid&&req_ready at posedge
//  req_we      in   1           1 = write, 0 = read
//  req_wmask   in   NUM_WMASKS  byte enables for writes (ignored on reads)
//  req_addr    in   ADDR_WIDTH  word address
//  req_wdata   in   DATA_WIDTH  write data
//  rsp_valid   out  1           response present; held until rsp_ready
//  rsp_ready   in   1           response consumed when rsp_valid&&rsp_ready at posedge
//  rsp_we      out  1           1 = response to a write (ack), 0 = read data
//  rsp_rdata   out  DATA_WIDTH  read data; unchanged on write responses
//  init_done   out  1           fill sweep complete; stays 1 until next reset
//  sram_csb    out  1           SRAM csb0 (active low)
//  sram_web    out  1           SRAM web0 (active low)
//  sram_wmask  out  NUM_WMASKS  SRAM wmask0
//  sram_addr   out  ADDR_WIDTH  SRAM addr0
//  sram_din    out  DATA_WIDTH  SRAM din0
//  sram_dout   in   DATA_WIDTH  SRAM dout0
// BEHAVIOUR
//  - All outputs are flops on posedge clk. Reset (async, any time incl. mid-transaction) forces
//    sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0, rsp_valid=0, rsp_we=0,
//    rsp_rdata=0, init_done=0, state=INIT (INIT_EN=1) or IDLE (INIT_EN=0). In-flight request is dropped.
//  - SRAM samples its inputs at the posedge after the one that drives them. Read data is valid from the
//    following negedge. It is captured at the next posedge.
//  - States: INIT, IDLE, CMD, WAIT, RESP.
//  - INIT: sram_csb=0, sram_web=0, wmask all 1s, din=INIT_VALUE, addr=0..RAM_DEPTH-1, one word per
//    cycle (back-to-back). After the cycle driving addr RAM_DEPTH-1 -> IDLE, csb=1, init_done=1.
//    Duration is exactly RAM_DEPTH cycles. req_ready=0 throughout.
//  - INIT_EN=0: INIT is skipped. init_done rises at the first posedge after resetn release.
//  - IDLE: req_ready=1 only here, and only when init_done=1. csb=1, web=1.
//    On accept at edge A -> CMD: drive csb=0, web=~req_we, addr, din, wmask (wmask forced 0 on reads).
//  - CMD lasts one cycle (SRAM samples at A+1) -> WAIT with csb=1, web=1.
//  - WAIT lasts one cycle. At edge A+2, capture rdata if read -> RESP: rsp_valid=1, rsp_we=req_we.
//  - Latency: accept at A -> rsp_valid high from A+2 for both reads and writes. A write is committed in
//    the array before rsp_valid rises.
//  - RESP: hold rsp_valid/rsp_rdata/rsp_we stable until rsp_ready. On handshake -> IDLE, rsp_valid=0.
//    Next accept is possible at the following edge. Peak throughput is 1 access per 4 cycles.
//  - Exactly one outstanding request. req_* are ignored outside IDLE. No data reordering.
//  - sram_csb never low outside CMD/INIT. web=0 only when csb=0 and the access is a write.
// TESTING  (bench drives the SRAM model with T_HOLD=1 so dout is stable across the capture edge)
//  1 reset, INIT_EN=1, INIT_VALUE=32'hA5A5A5A5 -> req_ready=0 for 256 cycles, init_done=1 at cycle 256;
//    then read addr 255 -> rsp_rdata=32'hA5A5A5A5.
//  2 write addr 8'h10 data 32'h12345678 wmask 4'b1111, then read 8'h10 -> rsp_we=1 ack, then rdata=32'h12345678
//    with rsp_valid exactly 2 cycles after each accept.
//  3 write 8'h10 data 32'hFFFFFFFF wmask 4'b0101 over 32'h12345678 -> read returns 32'h12FF56FF.
//  4 hold rsp_ready=0 for 5 cycles on a read -> rsp_valid/rsp_rdata stable, req_ready=0,
//    csb stays high, no new SRAM access.
//  5 assert resetn=0 during CMD of a write to 8'h20 -> outputs at reset values immediately;
//    INIT restarts and 8'h20 reads back INIT_VALUE.
//  6 INIT_EN=0, back-to-back reads of 8'h00 and 8'hFF with rsp_ready tied 1 -> accepts every
//    4 cycles, csb low exactly one cycle per access.

Source files
------------

// File: rtl/sram_rw_port_ctrl_if.sv
// Request/response channel between a user initiator and the SRAM RW port controller.
// The master drives requests and consumes responses. The slave (the controller) does the reverse.
interface sram_rw_port_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_we;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/sram_rw_port_ctrl.sv
// Initiator for the RW port (port 0) of a single-port OpenRAM SRAM macro.
// Accepts one read or byte-masked write at a time. It drives the macro with registered
// csb/web/wmask/addr/din. It captures dout one cycle after the macro samples the access
// and returns exactly one response per request. An optional sweep after reset fills the
// whole array with INIT_VALUE before user traffic is accepted.
module sram_rw_port_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    NUM_WMASKS = 4,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_rw_port_ctrl_if.slave    bus,
  output logic                  init_done,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_CMD  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  // With the fill disabled the controller wakes up directly in IDLE
  localparam logic [2:0] ST_RESET = (INIT_EN != 0) ? ST_INIT : ST_IDLE;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [NUM_WMASKS-1:0] MASK_NONE = {NUM_WMASKS{1'b0}};
  localparam logic [NUM_WMASKS-1:0] MASK_ALL  = {NUM_WMASKS{1'b1}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic [2:0]            state_r;
  logic                  we_r;
  logic                  init_done_r;
  logic                  req_ready_r;
  logic                  rsp_valid_r;
  logic                  rsp_we_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic                  sram_csb_r;
  logic                  sram_web_r;
  logic [NUM_WMASKS-1:0] sram_wmask_r;
  logic [ADDR_WIDTH-1:0] sram_addr_r;
  logic [DATA_WIDTH-1:0] sram_din_r;
  logic                  accept_s;
  logic                  rsp_done_s;

  // Decode the request and response handshakes for this cycle
  always_comb begin
    accept_s   = 1'b0;
    rsp_done_s = 1'b0;
    if (state_r == ST_IDLE) begin
      accept_s = init_done_r & req_ready_r & bus.req_valid;
    end else if (state_r == ST_RESP) begin
      rsp_done_s = rsp_valid_r & bus.rsp_ready;
    end else begin
      accept_s   = 1'b0;
      rsp_done_s = 1'b0;
    end
  end

  // Controller FSM: fill sweep, command issue, read capture and response hold
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_RESET;
      we_r         <= 1'b0;
      init_done_r  <= 1'b0;
      req_ready_r  <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_we_r     <= 1'b0;
      rsp_rdata_r  <= DATA_ZERO;
      sram_csb_r   <= 1'b1;
      sram_web_r   <= 1'b1;
      sram_wmask_r <= MASK_NONE;
      sram_addr_r  <= ADDR_ZERO;
      sram_din_r   <= DATA_ZERO;
    end else begin
      case (state_r)
        ST_INIT: begin
          // csb still high means the sweep has not started yet
          if (sram_csb_r) begin
            sram_csb_r   <= 1'b0;
            sram_web_r   <= 1'b0;
            sram_wmask_r <= MASK_ALL;
            sram_din_r   <= INIT_VALUE;
            sram_addr_r  <= ADDR_ZERO;
          end else if (sram_addr_r == ADDR_LAST) begin
            sram_csb_r   <= 1'b1;
            sram_web_r   <= 1'b1;
            sram_wmask_r <= MASK_NONE;
            init_done_r  <= 1'b1;
            req_ready_r  <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            sram_addr_r <= sram_addr_r + ADDR_ONE;
          end
        end
        ST_IDLE: begin
          // Reaching IDLE with init_done low only happens when the sweep is disabled
          if (!init_done_r) begin
            init_done_r <= 1'b1;
            req_ready_r <= 1'b1;
          end else if (accept_s) begin
            req_ready_r  <= 1'b0;
            we_r         <= bus.req_we;
            sram_csb_r   <= 1'b0;
            sram_web_r   <= ~bus.req_we;
            sram_addr_r  <= bus.req_addr;
            sram_din_r   <= bus.req_wdata;
            sram_wmask_r <= bus.req_we ? bus.req_wmask : MASK_NONE;
            state_r      <= ST_CMD;
          end else begin
            sram_csb_r <= 1'b1;
            sram_web_r <= 1'b1;
          end
        end
        ST_CMD: begin
          // The macro samples the access at this edge; deselect it straight away
          sram_csb_r <= 1'b1;
          sram_web_r <= 1'b1;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          // dout has been stable since the previous falling edge
          if (!we_r) begin
            rsp_rdata_r <= sram_dout;
          end else begin
            rsp_rdata_r <= rsp_rdata_r;
          end
          rsp_we_r    <= we_r;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_done_s) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          // Unreachable encodings fall back to a quiet IDLE
          sram_csb_r  <= 1'b1;
          sram_web_r  <= 1'b1;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_we    = rsp_we_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign init_done     = init_done_r;
  assign sram_csb      = sram_csb_r;
  assign sram_web      = sram_web_r;
  assign sram_wmask    = sram_wmask_r;
  assign sram_addr     = sram_addr_r;
  assign sram_din      = sram_din_r;

endmodule
